usb_rx: RTL
===========

# usb_rx

Low-speed USB receiver: recovers the bit clock from the D+/D- line by 4x oversampling, detects SYNC, NRZI-decodes, removes stuffed bits and delivers bytes to the SIE until EOP. It is the receive counterpart of the SIE's transmit path. It sits between the pad-level D+/D- inputs and the SIE packet decoder. Shares line-state types with the transmit path via package `types`.

## Interface
- No parameters; oversampling is fixed at 4 clocks per bit.
- `clk` in 1: system clock, 6 MHz for low speed.
- `reset` in 1: synchronous, active-high.
- `d_i` in `d_port_t`: USB port D+, D- (input). Ignored by the transmit side while it drives the bus.
- `data` out 8: received byte, LSB first on the wire. Valid only while `valid`=1. Reset 8'h00.
- `valid` out 1: one-cycle strobe per received byte. Reset 0.
- `active` out 1: high from SYNC accepted until EOP or abort. Reset 0.
- `eop` out 1: one-cycle strobe on completed EOP. Reset 0.
- `error` out 1: one-cycle strobe on stuff error, SE1, or non-byte-aligned EOP. Reset 0.

## Operation
- **Bit clock recovery**
  - 2-bit phase counter, cleared on any line-state change of the synchronized input.
  - Otherwise it increments and wraps.
  - Sample strobe when phase==2, i.e. mid-bit.
- **Line decode**
  - SE0 = both low; SE1 = both high.
  - J/K decoded to bits: NRZI bit = 1 if the sampled J/K equals the previous J/K sample, else 0.
  - The previous sample is initialised to J in RX_WAIT.
- **States** (enum, default -> RESET):
  - RESET -> RX_WAIT when !reset.
  - RX_WAIT: idle. First K sample -> RX_SYNC. SE0 ignored.
  - RX_SYNC: counts decoded 0s.
    - First decoded 1 with zero-count >=3 -> RX_DATA; `active` rises.
    - First decoded 1 with zero-count <3 -> RX_WAIT.
    - SE0 or SE1 -> RX_WAIT. No `error`.
  - RX_DATA: shifts unstuffed bits into an 8-bit register, LSB first. Bit counter 3 bits, wraps 7->0.
    - When the 8th bit is sampled, `data`/`valid` are loaded.
    - SE0 sample -> RX_EOP.
    - SE1, or stuff error -> RX_ABORT with `error` pulse.
  - RX_EOP:
    - J sample -> RX_WAIT with `eop` pulse. The pulse is issued in the same cycle as `error` if bit counter !=0 at SE0.
    - K or SE1 sample -> RX_ABORT with `error` pulse.
  - RX_ABORT: `active`=0. Waits for an SE0 sample followed by a J sample -> RX_WAIT. No `eop` is issued.
- **Unstuffing**
  - Ones counter 3 bits, counts consecutive decoded 1s; cleared by any 0.
  - At count 6, the next sampled bit is consumed without advancing the bit counter:
    - 0 -> discard it, counter cleared.
    - 1 -> stuff error.
  - A continuously idle (J) line in RX_DATA therefore ends in a stuff error, never a hang.
- `active` falls the cycle after leaving RX_DATA/RX_EOP.

## Timing
- `valid` asserts exactly 1 clk after the sample strobe of a byte's 8th data bit, for 1 clk.
- `data` holds until the next `valid`.
- `eop`/`error` assert 1 clk after the deciding sample strobe.
- Consecutive `valid` strobes are >=32 clk apart; +4 per stuffed bit.
- Input path latency (d_i to sampler) is 2 clk with USB_RX_SYNC_EN defined, 0 without. Phase counting is identical either way.
- Reset mid-packet: all outputs 0 on the next clk, state RESET, then RX_WAIT. The rest of that packet is discarded until the line idles. A K seen mid-packet after reset may falsely start SYNC, then fails and returns to RX_WAIT without `valid`.

## Configuration
- `USB_RX_SYNC_EN`
  - Defined: `d_i` passes through a 2-flop synchronizer per line before decode. Required for asynchronous pads.
  - Undefined: `d_i` is used directly, for simulation or externally synchronized inputs.

## Structure
- `d_port_t` and its SE0/J/K/SE1 constants, plus a new `RX_OVERSAMPLE` constant (=4), live in package `types`.
- One sub-module: `usb_dpll` holds the synchronizer, phase counter and sample strobe, and the J/K/SE0/SE1 decode.
- `usb_rx` keeps the FSM, NRZI decode, unstuffing and byte assembly.

## Test plan
- Line KJKJKJKK, then 0xA5 NRZI-encoded, then SE0 SE0 J, at 4 clk/bit -> one `valid` with `data`=8'hA5, then `eop`=1, `error` never 1.
- Bytes 0xFF,0xFF with stuffed 0s inserted -> two `valid`, `data`=8'hFF each, no `error`.
- Seven consecutive decoded 1s (unstuffed) -> `error` pulse, `active` falls, no further `valid` until next SYNC.
- SYNC, 0xC3, then 4 bits, then EOP -> `valid` 0xC3 once, then `eop` and `error` in the same cycle.
- Bit period jittered 3/5 clk alternately -> bytes 0x3C,0x5A received correctly.
- `reset` asserted mid-byte -> all outputs 0 next clk. Following full packet 0x69 -> `valid` with 8'h69.

Source files
------------

// File: rtl/types.sv
// Line-state types shared by the USB low-speed transmit and receive paths.
// RX_OVERSAMPLE fixes the receive oversampling ratio.
package types;

   typedef struct packed {
      logic dp;
      logic dm;
   } d_port_t;

   // Low speed: J is D- high, K is D+ high
   localparam d_port_t D_SE0 = 2'b00;
   localparam d_port_t D_J   = 2'b01;
   localparam d_port_t D_K   = 2'b10;
   localparam d_port_t D_SE1 = 2'b11;

   localparam int RX_OVERSAMPLE = 4;

   typedef enum logic [1:0] {
      LS_SE0,
      LS_J,
      LS_K,
      LS_SE1
   } line_t;

endpackage

// File: rtl/usb_dpll.sv
// Bit clock recovery and line decode for the USB receiver.
// Define USB_RX_SYNC_EN to add a 2-flop synchronizer on D+/D-.
module usb_dpll
   import types::*;
(
   input  logic    clk_i,
   input  logic    reset_i,
   input  d_port_t d_i,
   output logic    strobe_o,
   output line_t   line_o
);

   localparam logic [1:0] PH_MID = 2'(RX_OVERSAMPLE / 2);

   d_port_t    s;
   d_port_t    s_q;
   logic [1:0] phase_q;
   logic [1:0] phase_d;

`ifdef USB_RX_SYNC_EN
   d_port_t m1_q;
   d_port_t m2_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         m1_q <= D_J;
         m2_q <= D_J;
      end else begin
         m1_q <= d_i;
         m2_q <= m1_q;
      end
   end

   assign s = m2_q;
`else
   assign s = d_i;
`endif

   // Any edge re-centres the phase; strobe lands mid-bit
   always_comb begin
      phase_d = phase_q + 2'd1;
      if (s != s_q) phase_d = 2'd0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s_q     <= D_J;
         phase_q <= 2'd0;
      end else begin
         s_q     <= s;
         phase_q <= phase_d;
      end
   end

   assign strobe_o = (phase_q == PH_MID);

   always_comb begin
      line_o = LS_J;
      case (s_q)
         D_SE0:   line_o = LS_SE0;
         D_K:     line_o = LS_K;
         D_SE1:   line_o = LS_SE1;
         default: line_o = LS_J;
      endcase
   end

endmodule

// File: rtl/usb_rx.sv
// Low-speed USB receiver: SYNC detect, NRZI decode, unstuffing, bytes to SIE.
// USB_RX_SYNC_EN (in usb_dpll) selects a synchronized input path.
module usb_rx
   import types::*;
(
   input  logic       clk,
   input  logic       reset,
   input  d_port_t    d_i,
   output logic [7:0] data,
   output logic       valid,
   output logic       active,
   output logic       eop,
   output logic       error
);

   localparam logic [2:0] ST_RESET = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_SYNC  = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_EOP   = 3'd4;
   localparam logic [2:0] ST_ABORT = 3'd5;

   logic  strobe;
   line_t line;

   logic [2:0] state_q, state_d;
   line_t      prev_q, prev_d;
   logic [1:0] zcnt_q, zcnt_d;
   logic [2:0] bcnt_q, bcnt_d;
   logic [2:0] ones_q, ones_d;
   logic [6:0] sr_q, sr_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       eop_q, eop_d;
   logic       err_q, err_d;
   logic       se0_q, se0_d;
   logic       nrzi;

   usb_dpll u_dpll (
      .clk_i    (clk),
      .reset_i  (reset),
      .d_i      (d_i),
      .strobe_o (strobe),
      .line_o   (line)
   );

   assign nrzi = (line == prev_q);

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      zcnt_d  = zcnt_q;
      bcnt_d  = bcnt_q;
      ones_d  = ones_q;
      sr_d    = sr_q;
      data_d  = data_q;
      valid_d = 1'b0;
      eop_d   = 1'b0;
      err_d   = 1'b0;
      se0_d   = se0_q;
      if (state_q == ST_RESET) begin
         state_d = ST_WAIT;
         prev_d  = LS_J;
      end else if (strobe) begin
         case (state_q)
            ST_WAIT: begin
               prev_d = LS_J;
               zcnt_d = 2'd0;
               if (line == LS_K) begin
                  state_d = ST_SYNC;
                  prev_d  = LS_K;
                  zcnt_d  = 2'd1;
               end
            end
            ST_SYNC: begin
               if (line == LS_SE0 || line == LS_SE1) begin
                  state_d = ST_WAIT;
               end else begin
                  prev_d = line;
                  if (!nrzi) begin
                     if (zcnt_q != 2'd3) zcnt_d = zcnt_q + 2'd1;
                  end else if (zcnt_q == 2'd3) begin
                     state_d = ST_DATA;
                     bcnt_d  = 3'd0;
                     ones_d  = 3'd0;
                  end else begin
                     state_d = ST_WAIT;
                  end
               end
            end
            ST_DATA: begin
               if (line == LS_SE0) begin
                  state_d = ST_EOP;
               end else if (line == LS_SE1) begin
                  state_d = ST_ABORT;
                  err_d   = 1'b1;
                  se0_d   = 1'b0;
               end else begin
                  prev_d = line;
                  // After six 1s the next bit is a stuffed 0
                  if (ones_q == 3'd6) begin
                     ones_d = 3'd0;
                     if (nrzi) begin
                        state_d = ST_ABORT;
                        err_d   = 1'b1;
                        se0_d   = 1'b0;
                     end
                  end else begin
                     sr_d   = {nrzi, sr_q[6:1]};
                     bcnt_d = bcnt_q + 3'd1;
                     ones_d = nrzi ? ones_q + 3'd1 : 3'd0;
                     if (bcnt_q == 3'd7) begin
                        data_d  = {nrzi, sr_q};
                        valid_d = 1'b1;
                     end
                  end
               end
            end
            ST_EOP: begin
               if (line == LS_J) begin
                  state_d = ST_WAIT;
                  eop_d   = 1'b1;
                  err_d   = (bcnt_q != 3'd0);
               end else if (line != LS_SE0) begin
                  state_d = ST_ABORT;
                  err_d   = 1'b1;
                  se0_d   = 1'b0;
               end
            end
            ST_ABORT: begin
               if (line == LS_SE0) se0_d = 1'b1;
               else if (line == LS_J && se0_q) state_d = ST_WAIT;
               else se0_d = 1'b0;
            end
            default: state_d = ST_RESET;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RESET;
         prev_q  <= LS_J;
         zcnt_q  <= 2'd0;
         bcnt_q  <= 3'd0;
         ones_q  <= 3'd0;
         sr_q    <= 7'd0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         eop_q   <= 1'b0;
         err_q   <= 1'b0;
         se0_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         zcnt_q  <= zcnt_d;
         bcnt_q  <= bcnt_d;
         ones_q  <= ones_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         eop_q   <= eop_d;
         err_q   <= err_d;
         se0_q   <= se0_d;
      end
   end

   assign data   = data_q;
   assign valid  = valid_q;
   assign eop    = eop_q;
   assign error  = err_q;
   assign active = (state_q == ST_DATA) || (state_q == ST_EOP);

endmodule
